// File: rtl/pulse_period_averager_pkg.sv
// Shared defaults for the tach measurement path plus a small width helper.
// No ports; imported by pulse_edge_sync and pulse_period_averager.
package pulse_period_averager_pkg;

  localparam int unsigned DEF_CLK_RATE       = 50_000_000;
  localparam int unsigned DEF_RPM_WIDTH      = 16;
  localparam int unsigned DEF_PERIOD_WIDTH   = 32;
  localparam int unsigned DEF_NPOINT_AVG_2   = 3;
  localparam int unsigned DEF_NPOINT_AVG     = 2 ** DEF_NPOINT_AVG_2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Synchroniser plus registered rising-edge strobe for one asynchronous tach input.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   pulse_i - raw asynchronous input
//   edge_o  - one-cycle strobe, the cycle after the synchronised level rises
module pulse_edge_sync
  import pulse_period_averager_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      level_q <= sync_q[SYNC_STAGES-1];
      edge_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/pulse_period_averager.sv
// Tach period averager: measures clk cycles between rising edges of a raw
// pulse, keeps an N-point moving average, counts edges per fixed window and
// flags a stalled shaft.
// Ports:
//   clk               - system clock
//   rst               - asynchronous active-high reset
//   pulse             - raw asynchronous tach input
//   avg_period        - moving-average period in clk cycles
//   avg_valid         - averaging buffer holds NPOINT_AVG fresh samples
//   avg_update        - one-cycle strobe when avg_period is rewritten
//   pulse_rate        - rising edges counted in the last completed window
//   pulse_rate_change - toggles on every window completion
//   stalled           - no edge seen for TIMEOUT_CYCLES
module pulse_period_averager
  import pulse_period_averager_pkg::*;
#(
  parameter int unsigned CLK_RATE       = DEF_CLK_RATE,
  parameter int unsigned RPM_WIDTH      = DEF_RPM_WIDTH,
  parameter int unsigned PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
  parameter int unsigned NPOINT_AVG_2   = DEF_NPOINT_AVG_2,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pulse,
  output logic [PERIOD_WIDTH-1:0] avg_period,
  output logic                    avg_valid,
  output logic                    avg_update,
  output logic [RPM_WIDTH-1:0]    pulse_rate,
  output logic                    pulse_rate_change,
  output logic                    stalled
);

  localparam int unsigned NPOINT_AVG = 2 ** NPOINT_AVG_2;
  localparam int unsigned SUM_WIDTH  = PERIOD_WIDTH + NPOINT_AVG_2;
  localparam int unsigned IDX_WIDTH  = cnt_width(NPOINT_AVG);
  localparam int unsigned FILL_WIDTH = NPOINT_AVG_2 + 1;
  localparam int unsigned WIN_WIDTH  = cnt_width(CLK_RATE);

  localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_VAL = PERIOD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [FILL_WIDTH-1:0]   FILL_FULL   = FILL_WIDTH'(NPOINT_AVG);
  localparam logic [IDX_WIDTH-1:0]    IDX_LAST    = IDX_WIDTH'(NPOINT_AVG - 1);
  localparam logic [WIN_WIDTH-1:0]    WIN_LAST    = WIN_WIDTH'(CLK_RATE - 1);
  localparam logic [RPM_WIDTH-1:0]    RATE_MAX    = '1;

  logic                    pulse_edge;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic                    first_seen_q, first_seen_d;
  logic [SUM_WIDTH-1:0]    sum_q, sum_d, oldest;
  logic [FILL_WIDTH-1:0]   fill_q, fill_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [PERIOD_WIDTH-1:0] avg_period_q, avg_period_d;
  logic                    avg_valid_q, avg_valid_d;
  logic                    avg_update_q, avg_update_d;
  logic                    stalled_q, stalled_d;
  logic [WIN_WIDTH-1:0]    win_q, win_d;
  logic [RPM_WIDTH-1:0]    pulse_count_q, pulse_count_d, count_inc;
  logic [RPM_WIDTH-1:0]    pulse_rate_q, pulse_rate_d;
  logic                    rate_change_q, rate_change_d;
  logic                    sample_wr;
  logic [PERIOD_WIDTH-1:0] buf_q [NPOINT_AVG];

  pulse_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pulse_i(pulse),
    .edge_o (pulse_edge)
  );

  // The very first edge only starts the timer; a sample needs two edges.
  assign sample_wr = pulse_edge & first_seen_q;

  always_comb begin
    timer_d      = timer_q;
    first_seen_d = first_seen_q;
    sum_d        = sum_q;
    fill_d       = fill_q;
    idx_d        = idx_q;
    wr_d         = 1'b0;
    stalled_d    = stalled_q;
    avg_period_d = avg_period_q;
    avg_valid_d  = avg_valid_q;
    avg_update_d = 1'b0;
    // Only a full buffer has an entry that is about to be overwritten.
    oldest = (fill_q == FILL_FULL) ? SUM_WIDTH'(buf_q[idx_q]) : '0;

    // An edge wins over a coincident timeout and is recorded as a normal sample.
    if (pulse_edge) begin
      timer_d      = PERIOD_WIDTH'(1);
      first_seen_d = 1'b1;
      stalled_d    = 1'b0;
      if (first_seen_q) begin
        sum_d  = sum_q + SUM_WIDTH'(timer_q) - oldest;
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        wr_d   = 1'b1;
      end
    end else if (timer_q == TIMEOUT_VAL) begin
      first_seen_d = 1'b0;
      sum_d        = '0;
      fill_d       = '0;
      idx_d        = '0;
      stalled_d    = 1'b1;
      avg_valid_d  = 1'b0;
      avg_period_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // The timer was just reloaded when wr_q is set, so this never meets a timeout.
    if (wr_q) begin
      avg_update_d = 1'b1;
      avg_period_d = sum_q[SUM_WIDTH-1:NPOINT_AVG_2];
      avg_valid_d  = (fill_q == FILL_FULL);
    end
  end

  always_comb begin
    count_inc = (pulse_edge && (pulse_count_q != RATE_MAX)) ? pulse_count_q + 1'b1
                                                           : pulse_count_q;
    if (win_q == WIN_LAST) begin
      win_d         = '0;
      pulse_count_d = '0;
      pulse_rate_d  = count_inc;
      rate_change_d = ~rate_change_q;
    end else begin
      win_d         = win_q + 1'b1;
      pulse_count_d = count_inc;
      pulse_rate_d  = pulse_rate_q;
      rate_change_d = rate_change_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q       <= '0;
      first_seen_q  <= 1'b0;
      sum_q         <= '0;
      fill_q        <= '0;
      idx_q         <= '0;
      wr_q          <= 1'b0;
      avg_period_q  <= '0;
      avg_valid_q   <= 1'b0;
      avg_update_q  <= 1'b0;
      stalled_q     <= 1'b0;
      win_q         <= '0;
      pulse_count_q <= '0;
      pulse_rate_q  <= '0;
      rate_change_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      first_seen_q  <= first_seen_d;
      sum_q         <= sum_d;
      fill_q        <= fill_d;
      idx_q         <= idx_d;
      wr_q          <= wr_d;
      avg_period_q  <= avg_period_d;
      avg_valid_q   <= avg_valid_d;
      avg_update_q  <= avg_update_d;
      stalled_q     <= stalled_d;
      win_q         <= win_d;
      pulse_count_q <= pulse_count_d;
      pulse_rate_q  <= pulse_rate_d;
      rate_change_q <= rate_change_d;
    end
  end

  // Stale entries are harmless: they are only subtracted once fill is full again.
  always_ff @(posedge clk) begin
    if (sample_wr) buf_q[idx_q] <= timer_q;
  end

  assign avg_period        = avg_period_q;
  assign avg_valid         = avg_valid_q;
  assign avg_update        = avg_update_q;
  assign pulse_rate        = pulse_rate_q;
  assign pulse_rate_change = rate_change_q;
  assign stalled           = stalled_q;

endmodule

// File: tb/tb_pulse_period_averager.sv
// Directed bench for pulse_period_averager. A pulse sampled high at posedge R
// produces the edge strobe after posedge R+2, the sample write at R+3 and the
// avg_update strobe after R+4.
module tb_pulse_period_averager;

  localparam int CLK_RATE       = 100;
  localparam int RPM_WIDTH      = 8;
  localparam int PERIOD_WIDTH   = 16;
  localparam int NPOINT_AVG_2   = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SAT_CLK_RATE   = 700;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;
  logic pulse2 = 1'b0;

  logic [PERIOD_WIDTH-1:0] avg_period, avg_period2;
  logic                    avg_valid, avg_valid2;
  logic                    avg_update, avg_update2;
  logic [RPM_WIDTH-1:0]    pulse_rate, pulse_rate2;
  logic                    pulse_rate_change, pulse_rate_change2;
  logic                    stalled, stalled2;

  pulse_period_averager #(
    .CLK_RATE(CLK_RATE), .RPM_WIDTH(RPM_WIDTH), .PERIOD_WIDTH(PERIOD_WIDTH),
    .NPOINT_AVG_2(NPOINT_AVG_2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .pulse(pulse),
    .avg_period(avg_period), .avg_valid(avg_valid), .avg_update(avg_update),
    .pulse_rate(pulse_rate), .pulse_rate_change(pulse_rate_change), .stalled(stalled)
  );

  // Longer window so that more than 255 edges fit into one window.
  pulse_period_averager #(
    .CLK_RATE(SAT_CLK_RATE), .RPM_WIDTH(RPM_WIDTH), .PERIOD_WIDTH(PERIOD_WIDTH),
    .NPOINT_AVG_2(NPOINT_AVG_2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .pulse(pulse2),
    .avg_period(avg_period2), .avg_valid(avg_valid2), .avg_update(avg_update2),
    .pulse_rate(pulse_rate2), .pulse_rate_change(pulse_rate_change2), .stalled(stalled2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int upd_cyc[$];
  int upd_per[$];
  int upd_val[$];

  always @(negedge clk) begin
    if (!rst && avg_update) begin
      upd_cyc.push_back(cyc);
      upd_per.push_back(int'(avg_period));
      upd_val.push_back(int'(avg_valid));
    end
  end

  int rise_q[$];

  function automatic bit is_high(input int t);
    foreach (rise_q[i]) if (t >= rise_q[i] && t < rise_q[i] + 3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(output int b);
    rst = 1'b1;
    pulse = 1'b0;
    pulse2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    upd_cyc.delete();
    upd_per.delete();
    upd_val.delete();
    rise_q.delete();
    b = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_avg_period"}, avg_period, 0);
    chk_eq({tag, "_avg_valid"}, avg_valid, 0);
    chk_eq({tag, "_avg_update"}, avg_update, 0);
    chk_eq({tag, "_pulse_rate"}, pulse_rate, 0);
    chk_eq({tag, "_rate_change"}, pulse_rate_change, 0);
    chk_eq({tag, "_stalled"}, stalled, 0);
  endtask

  // Expected avg_update sequence for the main run: which rise caused it,
  // the truncated average and avg_valid.
  int exp_idx[13] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14};
  int exp_per[13] = '{2, 5, 7, 10, 15, 20, 25, 30, 2, 5, 7, 10, 23};
  int exp_val[13] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
  int gaps[8]     = '{10, 10, 10, 10, 30, 30, 30, 30};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base, t, r_stall, r_rec, r_last;

    // Reset state
    apply_reset(base);
    chk_all_zero("reset");

    // Steady train, averaging, stall, recovery and edge coincident with timeout
    apply_reset(base);
    t = base + 5;
    rise_q.push_back(t);
    foreach (gaps[i]) begin
      t += gaps[i];
      rise_q.push_back(t);
    end
    r_stall = t;
    t = r_stall + 100;
    r_rec = t;
    rise_q.push_back(t);
    for (int i = 0; i < 4; i++) begin
      t += 10;
      rise_q.push_back(t);
    end
    t += 64;
    r_last = t;
    rise_q.push_back(t);

    for (int n = base; n < r_last + 10; n++) begin
      pulse = is_high(n + 1);
      if (n == r_stall + 66) begin
        chk_eq("pre_stall_stalled", stalled, 0);
        chk_eq("pre_stall_avg", avg_period, 30);
        chk_eq("pre_stall_valid", avg_valid, 1);
      end
      if (n == r_stall + 67) begin
        chk_eq("stall_stalled", stalled, 1);
        chk_eq("stall_valid", avg_valid, 0);
        chk_eq("stall_avg", avg_period, 0);
      end
      if (n == r_rec + 2) chk_eq("recover_still_stalled", stalled, 1);
      if (n == r_rec + 3) chk_eq("recover_cleared", stalled, 0);
      if (n == r_last + 8) chk_eq("coincident_no_stall", stalled, 0);
      tick();
    end

    chk_eq("upd_count", upd_cyc.size(), 13);
    for (int i = 0; i < 13; i++) begin
      if (i < upd_cyc.size()) begin
        chk_eq($sformatf("upd%0d_cycle", i), upd_cyc[i], rise_q[exp_idx[i]] + 4);
        chk_eq($sformatf("upd%0d_avg", i), upd_per[i], exp_per[i]);
        chk_eq($sformatf("upd%0d_valid", i), upd_val[i], exp_val[i]);
      end
    end

    // Asynchronous reset while the average is valid
    chk_eq("pre_reset_valid", avg_valid, 1);
    chk_eq("pre_reset_avg", avg_period, 23);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    repeat (2) tick();
    rst = 1'b0;
    base = cyc;
    upd_cyc.delete();
    upd_per.delete();
    upd_val.delete();
    rise_q.delete();
    rise_q.push_back(base + 5);
    rise_q.push_back(base + 15);
    for (int n = base; n < base + 30; n++) begin
      pulse = is_high(n + 1);
      tick();
    end
    chk_eq("post_reset_upd_count", upd_cyc.size(), 1);
    if (upd_cyc.size() > 0) begin
      chk_eq("post_reset_upd_cycle", upd_cyc[0], base + 19);
      chk_eq("post_reset_upd_avg", upd_per[0], 2);
      chk_eq("post_reset_upd_valid", upd_val[0], 0);
    end

    // Window counting, boundary edge and saturation
    apply_reset(base);
    for (int j = 0; j < 20; j++) rise_q.push_back(base + 10 * j + 7);
    rise_q.push_back(base + 297);
    for (int n = base; n < base + 705; n++) begin
      pulse = is_high(n + 1);
      pulse2 = (n < base + 700) ? n[0] : 1'b0;
      if (n == base + 99) begin
        chk_eq("win0_open_rate", pulse_rate, 0);
        chk_eq("win0_open_change", pulse_rate_change, 0);
      end
      if (n == base + 100) begin
        chk_eq("win0_rate", pulse_rate, 10);
        chk_eq("win0_change", pulse_rate_change, 1);
      end
      if (n == base + 200) begin
        chk_eq("win1_rate", pulse_rate, 10);
        chk_eq("win1_change", pulse_rate_change, 0);
      end
      if (n == base + 300) begin
        chk_eq("win2_boundary_rate", pulse_rate, 1);
        chk_eq("win2_change", pulse_rate_change, 1);
      end
      if (n == base + 400) begin
        chk_eq("win3_rate", pulse_rate, 0);
        chk_eq("win3_change", pulse_rate_change, 0);
      end
      if (n == base + 699) chk_eq("sat_open_rate", pulse_rate2, 0);
      if (n == base + 700) begin
        chk_eq("sat_rate", pulse_rate2, 255);
        chk_eq("sat_change", pulse_rate_change2, 1);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
